// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-resolve signal bundle between the pipeline and the branch predictor.
// The master side is the pipeline and the slave side is the predictor.
interface branch_predictor_if #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned CNT_W = 16
);
   logic [PC_W-1:0]  if_pc;
   logic             pred_taken;
   logic [31:0]      pred_target;
   logic             ex_branch;
   logic             ex_taken;
   logic [PC_W-1:0]  ex_pc;
   logic [31:0]      ex_imm;
   logic             ex_pred_taken;
   logic [31:0]      ex_pred_target;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   modport master (
      output if_pc, ex_branch, ex_taken, ex_pc, ex_imm, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, mispredict, redirect_pc, branch_count, mispredict_count
   );

   modport slave (
      input  if_pc, ex_branch, ex_taken, ex_pc, ex_imm, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, mispredict, redirect_pc, branch_count, mispredict_count
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// EX-stage resolve/redirect, table training and saturating performance counters.
module branch_predictor #(
   parameter int unsigned PC_W    = 9,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 16
) (
   input logic               clk,
   input logic               reset,
   branch_predictor_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = PC_W - IDX_W - 2;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [CNT_W-1:0]   branch_count_q;
   logic [CNT_W-1:0]   mispredict_count_q;

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;
   logic [31:0]      ex_pc_ext, taken_target, actual;

   assign if_idx = bus.if_pc[IDX_W+1:2];
   assign if_tag = bus.if_pc[PC_W-1:IDX_W+2];
   assign ex_idx = bus.ex_pc[IDX_W+1:2];
   assign ex_tag = bus.ex_pc[PC_W-1:IDX_W+2];

   always_comb begin
      if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      bus.pred_taken  = if_hit && ctr_q[if_idx][1];
      bus.pred_target = bus.pred_taken ? target_q[if_idx] : 32'(bus.if_pc) + 32'd4;
   end

   always_comb begin
      ex_pc_ext       = 32'(bus.ex_pc);
      taken_target    = ex_pc_ext + bus.ex_imm;
      actual          = bus.ex_taken ? taken_target : ex_pc_ext + 32'd4;
      ex_hit          = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      bus.redirect_pc = actual;
      bus.mispredict  = !reset && bus.ex_branch &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_pred_target != actual)));
   end

   // A taken miss replaces whatever entry aliases at this index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (bus.ex_branch) begin
         if (ex_hit) begin
            if (bus.ex_taken) begin
               target_q[ex_idx] <= taken_target;
               if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
            end else if (ctr_q[ex_idx] != 2'b00) begin
               ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
            end
         end else if (bus.ex_taken) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= taken_target;
            ctr_q[ex_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         if (bus.ex_branch && (branch_count_q != '1)) branch_count_q <= branch_count_q + 1'b1;
         if (bus.mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_q <= mispredict_count_q + 1'b1;
         end
      end
   end

   assign bus.branch_count     = branch_count_q;
   assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level reference model checked every cycle,
// plus hand-computed literal expectations from the scenario list.
module tb_branch_predictor;
   localparam int unsigned PC_W    = 9;
   localparam int unsigned ENTRIES = 16;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned IDX_W   = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   branch_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Reference model: one record per BTB slot, counter held as an integer 0..3.
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   bit [31:0]   m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int unsigned m_branches;
   int unsigned m_mispredicts;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < int'(ENTRIES); i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_target[i] = '0;
         m_ctr[i]    = 1;
      end
      m_branches    = 0;
      m_mispredicts = 0;
   endfunction

   function automatic int unsigned slot(input int unsigned pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input int unsigned pc);
      return pc >> (IDX_W + 2);
   endfunction

   // Compare process: 2 time units before each rising edge, then advance the model past it.
   initial begin
      bit          hit, exp_pt, exp_mp;
      bit [31:0]   exp_tgt, act_pc;
      int unsigned s;
      model_reset();
      forever begin
         @(posedge clk);
         #8;
         if (reset) model_reset();
         s       = slot(32'(bus.if_pc));
         hit     = m_valid[s] && m_tag[s] == tag_of(32'(bus.if_pc));
         exp_pt  = hit && m_ctr[s] >= 2;
         exp_tgt = exp_pt ? m_target[s] : 32'(bus.if_pc) + 32'd4;
         act_pc  = bus.ex_taken ? 32'(bus.ex_pc) + bus.ex_imm : 32'(bus.ex_pc) + 32'd4;
         exp_mp  = !reset && bus.ex_branch && (bus.ex_taken != bus.ex_pred_taken ||
                   (bus.ex_taken && bus.ex_pred_target != act_pc));
         check("model_pred_taken", 32'(bus.pred_taken), 32'(exp_pt));
         check("model_pred_target", bus.pred_target, exp_tgt);
         check("model_mispredict", 32'(bus.mispredict), 32'(exp_mp));
         if (exp_mp) check("model_redirect_pc", bus.redirect_pc, act_pc);
         check("model_branch_count", 32'(bus.branch_count), m_branches);
         check("model_mispredict_count", 32'(bus.mispredict_count), m_mispredicts);
         if (!reset && bus.ex_branch) begin
            s   = slot(32'(bus.ex_pc));
            hit = m_valid[s] && m_tag[s] == tag_of(32'(bus.ex_pc));
            if (hit) begin
               if (bus.ex_taken) begin
                  m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                  m_target[s] = act_pc;
               end else begin
                  m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
               end
            end else if (bus.ex_taken) begin
               m_valid[s]  = 1'b1;
               m_tag[s]    = tag_of(32'(bus.ex_pc));
               m_target[s] = act_pc;
               m_ctr[s]    = 2;
            end
            if (m_branches < 65535) m_branches++;
            if (exp_mp && m_mispredicts < 65535) m_mispredicts++;
         end
      end
   end

   // Applies one cycle of inputs 2 units after the edge, returns 3 units later.
   task automatic cyc(input logic [8:0] ifpc, input logic br, input logic tk,
                      input logic [8:0] pc, input logic [31:0] imm,
                      input logic ptk, input logic [31:0] ptgt);
      @(posedge clk);
      #2;
      bus.if_pc          = ifpc;
      bus.ex_branch      = br;
      bus.ex_taken       = tk;
      bus.ex_pc          = pc;
      bus.ex_imm         = imm;
      bus.ex_pred_taken  = ptk;
      bus.ex_pred_target = ptgt;
      #3;
   endtask

   task automatic idle(input logic [8:0] ifpc);
      cyc(ifpc, 1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      bus.if_pc          = '0;
      bus.ex_branch      = 1'b0;
      bus.ex_taken       = 1'b0;
      bus.ex_pc          = '0;
      bus.ex_imm         = '0;
      bus.ex_pred_taken  = 1'b0;
      bus.ex_pred_target = '0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      // Cold table
      idle(9'h040);
      check("cold_pred_taken", 32'(bus.pred_taken), 32'd0);
      check("cold_pred_target", bus.pred_target, 32'h44);
      cyc(9'h040, 1'b1, 1'b1, 9'h040, 32'h20, 1'b0, 32'h0);
      check("alloc_mispredict", 32'(bus.mispredict), 32'd1);
      check("alloc_redirect", bus.redirect_pc, 32'h60);
      check("no_bypass_pred_taken", 32'(bus.pred_taken), 32'd0);
      idle(9'h040);
      check("alloc_pred_taken", 32'(bus.pred_taken), 32'd1);
      check("alloc_pred_target", bus.pred_target, 32'h60);

      // Hysteresis: 10 -> 01, then three takens to 11, then one not-taken to 10
      cyc(9'h040, 1'b1, 1'b0, 9'h040, 32'h20, 1'b1, 32'h60);
      check("nt_mispredict", 32'(bus.mispredict), 32'd1);
      check("nt_redirect", bus.redirect_pc, 32'h44);
      idle(9'h040);
      check("ctr01_pred_taken", 32'(bus.pred_taken), 32'd0);
      cyc(9'h040, 1'b1, 1'b1, 9'h040, 32'h20, 1'b0, 32'h0);
      cyc(9'h040, 1'b1, 1'b1, 9'h040, 32'h20, 1'b1, 32'h60);
      cyc(9'h040, 1'b1, 1'b1, 9'h040, 32'h20, 1'b1, 32'h60);
      cyc(9'h040, 1'b1, 1'b0, 9'h040, 32'h20, 1'b1, 32'h60);
      idle(9'h040);
      check("ctr10_pred_taken", 32'(bus.pred_taken), 32'd1);
      check("ctr10_pred_target", bus.pred_target, 32'h60);

      // Correct prediction
      cyc(9'h040, 1'b1, 1'b1, 9'h040, 32'h20, 1'b1, 32'h60);
      check("correct_mispredict", 32'(bus.mispredict), 32'd0);
      idle(9'h040);
      check("branch_count_7", 32'(bus.branch_count), 32'd7);
      check("mispredict_count_4", 32'(bus.mispredict_count), 32'd4);

      // Not-taken miss leaves the table alone
      cyc(9'h080, 1'b1, 1'b0, 9'h080, 32'h40, 1'b0, 32'h0);
      check("ntmiss_mispredict", 32'(bus.mispredict), 32'd0);
      idle(9'h080);
      check("ntmiss_pred_taken", 32'(bus.pred_taken), 32'd0);
      check("ntmiss_pred_target", bus.pred_target, 32'h84);

      // Alias at index 0 replaces the 0x40 entry
      cyc(9'h140, 1'b1, 1'b1, 9'h140, 32'h10, 1'b0, 32'h0);
      check("alias_mispredict", 32'(bus.mispredict), 32'd1);
      check("alias_redirect", bus.redirect_pc, 32'h150);
      idle(9'h040);
      check("alias_old_miss", 32'(bus.pred_taken), 32'd0);
      check("alias_old_target", bus.pred_target, 32'h44);
      idle(9'h140);
      check("alias_new_hit", 32'(bus.pred_taken), 32'd1);
      check("alias_new_target", bus.pred_target, 32'h150);

      // Direction right, target wrong
      cyc(9'h040, 1'b1, 1'b1, 9'h040, 32'h20, 1'b1, 32'h64);
      check("tgt_mismatch_mispredict", 32'(bus.mispredict), 32'd1);
      check("tgt_mismatch_redirect", bus.redirect_pc, 32'h60);

      // Mid-cycle asynchronous reset with a mispredicting branch in EX
      cyc(9'h040, 1'b1, 1'b1, 9'h040, 32'h20, 1'b0, 32'h0);
      check("pre_reset_pred_taken", 32'(bus.pred_taken), 32'd1);
      check("pre_reset_mispredict", 32'(bus.mispredict), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("reset_pred_taken", 32'(bus.pred_taken), 32'd0);
      check("reset_pred_target", bus.pred_target, 32'h44);
      check("reset_mispredict", 32'(bus.mispredict), 32'd0);
      check("reset_branch_count", 32'(bus.branch_count), 32'd0);
      check("reset_mispredict_count", 32'(bus.mispredict_count), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      bus.ex_branch = 1'b0;
      idle(9'h140);
      check("post_reset_alias_miss", 32'(bus.pred_taken), 32'd0);
      check("post_reset_count", 32'(bus.branch_count), 32'd0);
      idle(9'h000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
